uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter of the LM32 system between NREQ byte-stream requesters, e.g. CPU console, GPIO event reporter and debug monitor.
- Round-robin arbitration with packet lock: a granted requester keeps the UART until it sends a byte flagged last, or until it stalls past a timeout.
- Sits between the requesters and the uart_core tx_wr/tx_data/tx_busy interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, idle cycles before a stalled granted requester loses the grant; 0 disables the timeout.
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  requester i has a byte available.
- req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i].
- req_last  in  NREQ  the byte of requester i ends its packet.
- req_ready  out  NREQ  combinational; byte of requester i is accepted this cycle.
- grant  out  NREQ  registered one-hot grant.
- tx_data  out  8  registered byte to the UART.
- tx_wr  out  1  registered one-cycle write strobe to the UART.
- tx_busy  in  1  UART transmitter busy.
- arb_busy  out  1  high whenever state is not IDLE.
- timeout_evt  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst=0 sampled on a clk edge): state=IDLE, grant=0, tx_wr=0, tx_data=8'h00, timeout_evt=0, count=0, last_idx=NREQ-1 (requester 0 has first priority).
- Reset overrides everything, including an in-flight packet. Any byte already strobed is not retracted.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - If any req_valid is high, pick the first set index searching last_idx+1, last_idx+2, ... modulo NREQ.
  - Register grant, set sel and last_idx to that index, go to GRANT.
  - Latency: grant rises one cycle after req_valid is seen.
  - No byte is accepted in IDLE.
- GRANT:
  - req_ready[sel] = req_valid[sel] & ~tx_busy. All other req_ready bits are 0.
  - On a handshake: next cycle tx_wr=1 and tx_data=req_data[sel]. Latch lastflag=req_last[sel], clear count, go to DRAIN.
  - If req_valid[sel]=0: count increments.
  - If TIMEOUT!=0 and count reaches TIMEOUT-1 while req_valid[sel] is still 0: go to IDLE, clear grant, pulse timeout_evt for one cycle, clear count.
  - If req_valid[sel]=1 but tx_busy=1: count holds.
- DRAIN:
  - tx_wr is 1 only in the first DRAIN cycle.
  - The first DRAIN cycle ignores tx_busy, covering the UART's one-cycle busy assertion latency.
  - From the second cycle on, when tx_busy=0: if lastflag, go to IDLE with grant cleared; otherwise go to GRANT.
  - Per-byte cost: at least 3 cycles plus UART frame time.
- Throughput: at most one tx_wr per UART frame. tx_wr is never issued while tx_busy=1 in GRANT.
- Changes to req_valid of non-granted requesters never affect the current packet.
- Requester i dropping req_valid before it is granted: no effect. Arbitration uses only the valid bits present in IDLE.
- Granted requester asserting req_last on its first byte: a single-byte packet.
- NREQ=1: degenerates to pass-through with the same latencies.
- grant is a one-hot or zero vector at all times. req_ready is never set for a non-granted index.

Test Plan:
- Single requester: reset 4 cycles, then req 0 sends 8'h48 and 8'h69 with last on the second byte. Required: grant=4'b0001 one cycle after valid; two tx_wr pulses with data 48 then 69, each after tx_busy clears; grant=0 after the second drain.
- Round robin: all four valid from reset, each with a 1-byte packet. Required: grants in order 0,1,2,3. Then requests 0 and 2 arrive again after grant 3, and 0 is granted before 2.
- Packet lock: req 1 sends a 3-byte packet while req 0 is valid throughout. Required: three consecutive tx_wr from requester 1 with no req_ready[0] in between, then grant moves to 0.
- Timeout: TIMEOUT=16, req 2 granted, sends one non-last byte, then drops valid. Required: timeout_evt pulses exactly once, 16 cycles after re-entering GRANT; grant=0; req 3 is then granted.
- tx_busy hold: hold tx_busy=1 for 50 cycles with req 0 valid in GRANT. Required: no tx_wr and req_ready[0]=0 during the hold; tx_wr one cycle after the handshake once tx_busy falls.
- Reset mid-packet: assert rst=0 during DRAIN of a 2-byte packet. Required: next cycle grant=0, tx_wr=0, arb_busy=0; after release, requester 0 has priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte-stream requesters.
// A granted requester keeps the UART until its last byte drains or it stalls past TIMEOUT.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic              arb_busy,
  output logic              timeout_evt
);

  localparam int               IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit               TO_EN     = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [NREQ-1:0]  grant_r, grant_s;
  logic [IDX_W-1:0] sel_r, sel_s;
  logic [IDX_W-1:0] last_idx_r, last_idx_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             lastflag_r, lastflag_s;
  logic             tx_wr_r, tx_wr_s;
  logic [7:0]       tx_data_r, tx_data_s;
  logic             timeout_evt_r, timeout_evt_s;
  logic [NREQ-1:0]  req_ready_s;
  logic [IDX_W-1:0] cand_s, pick_s;
  logic             hit_s, found_s;

  // State and registered outputs; reset abandons any in-flight packet
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      grant_r       <= '0;
      sel_r         <= '0;
      last_idx_r    <= LAST_RST;
      count_r       <= '0;
      lastflag_r    <= 1'b0;
      tx_wr_r       <= 1'b0;
      tx_data_r     <= 8'h00;
      timeout_evt_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      grant_r       <= grant_s;
      sel_r         <= sel_s;
      last_idx_r    <= last_idx_s;
      count_r       <= count_s;
      lastflag_r    <= lastflag_s;
      tx_wr_r       <= tx_wr_s;
      tx_data_r     <= tx_data_s;
      timeout_evt_r <= timeout_evt_s;
    end
  end

  // Next-state logic, round-robin pick and the combinational ready handshake
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    sel_s         = sel_r;
    last_idx_s    = last_idx_r;
    count_s       = count_r;
    lastflag_s    = lastflag_r;
    tx_wr_s       = 1'b0;
    tx_data_s     = tx_data_r;
    timeout_evt_s = 1'b0;
    req_ready_s   = '0;
    cand_s        = '0;
    hit_s         = 1'b0;
    pick_s        = last_idx_r;
    found_s       = 1'b0;

    // Search starts just after the previous winner so every requester gets a turn
    for (int k = 1; k <= NREQ; k++) begin
      cand_s  = IDX_W'((int'(last_idx_r) + k) % NREQ);
      hit_s   = req_valid[cand_s] & ~found_s;
      pick_s  = hit_s ? cand_s : pick_s;
      found_s = found_s | hit_s;
    end

    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s         = ST_GRANT;
          grant_s         = '0;
          grant_s[pick_s] = 1'b1;
          sel_s           = pick_s;
          last_idx_s      = pick_s;
          count_s         = '0;
        end else begin
          grant_s = '0;
        end
      end
      ST_GRANT: begin
        req_ready_s[sel_r] = req_valid[sel_r] & ~tx_busy;
        if (req_valid[sel_r] && !tx_busy) begin
          tx_wr_s    = 1'b1;
          tx_data_s  = req_data[{sel_r, 3'b000} +: 8];
          lastflag_s = req_last[sel_r];
          count_s    = '0;
          state_s    = ST_DRAIN;
        end else if (!req_valid[sel_r]) begin
          if (TO_EN && (count_r == CNT_LIMIT)) begin
            state_s       = ST_IDLE;
            grant_s       = '0;
            timeout_evt_s = 1'b1;
            count_s       = '0;
          end else begin
            count_s = count_r + CNT_W'(1);
          end
        end else begin
          count_s = count_r;
        end
      end
      ST_DRAIN: begin
        // tx_wr_r marks the first drain cycle, where the UART has not raised busy yet
        if (!tx_wr_r && !tx_busy) begin
          if (lastflag_r) begin
            state_s = ST_IDLE;
            grant_s = '0;
          end else begin
            state_s = ST_GRANT;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
      end
    endcase
  end

  assign req_ready   = req_ready_s;
  assign grant       = grant_r;
  assign tx_data     = tx_data_r;
  assign tx_wr       = tx_wr_r;
  assign timeout_evt = timeout_evt_r;
  assign arb_busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester byte queues, a simple UART busy model
// and a packet-level round-robin reference that predicts the transmitted (requester, byte) stream.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  grant;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          tx_busy = 1'b0;
  logic          arb_busy;
  logic          timeout_evt;

  uart_tx_arbiter #(.NREQ(N), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_wr(tx_wr), .tx_busy(tx_busy), .arb_busy(arb_busy), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  logic [8:0] pq [N][$];   // per requester: {last, data}
  logic [9:0] expq [$];    // expected stream: {requester, data}
  bit         en [N];
  bit         force_busy;
  int         busy_cnt, frame_fix, cyc, hs_cyc, wr_cyc, evt_cyc, n_to, n_wr, model_last;
  int         errors = 0;
  int         checks = 0;

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    return s;
  endfunction

  // Packet-level round robin: every non-empty queue is valid whenever the arbiter is idle
  task automatic model_schedule();
    logic [8:0] q [N][$];
    logic [8:0] b;
    int j;
    bit done = 1'b0;
    for (int i = 0; i < N; i++) q[i] = pq[i];
    while (!done) begin
      j = -1;
      for (int k = 1; k <= N; k++)
        if (j < 0 && q[(model_last + k) % N].size() > 0) j = (model_last + k) % N;
      if (j < 0) begin
        done = 1'b1;
      end else begin
        do begin
          b = q[j].pop_front();
          expq.push_back({j[1:0], b[7:0]});
        end while (!b[8] && q[j].size() > 0);
        model_last = j;
      end
    end
  endtask

  // One clock: observe at negedge, model the UART, drive requesters, record handshakes
  task automatic cycle();
    logic [9:0] e;
    logic [8:0] h;
    @(negedge clk);
    cyc++;
    checks++;
    if (!$onehot0(grant)) begin
      errors++; $display("FAIL grant_onehot: got %b", grant);
    end
    if (tx_wr) begin
      n_wr++;
      wr_cyc = cyc;
      checks++;
      if (cyc != hs_cyc + 1) begin
        errors++; $display("FAIL wr_latency: wr at %0d, handshake at %0d, want wr at %0d", cyc, hs_cyc, hs_cyc + 1);
      end
      checks++;
      if (expq.size() == 0) begin
        errors++; $display("FAIL unexpected_wr: data %h grant %b, no byte expected", tx_data, grant);
      end else begin
        e = expq.pop_front();
        if (tx_data !== e[7:0] || grant !== (4'b0001 << e[9:8])) begin
          errors++;
          $display("FAIL tx_byte: got data %h grant %b, want data %h from requester %0d", tx_data, grant, e[7:0], e[9:8]);
        end
      end
      busy_cnt = (frame_fix > 0) ? frame_fix : $urandom_range(1, 8);
    end
    if (timeout_evt) begin
      n_to++;
      evt_cyc = cyc;
    end
    tx_busy = force_busy | (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    for (int i = 0; i < N; i++) begin
      if (en[i] && pq[i].size() > 0) begin
        h = pq[i][0];
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i] = h[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
    #1;
    checks++;
    if ((req_ready & ~grant) !== 4'b0000 || (tx_busy && req_ready !== 4'b0000)) begin
      errors++; $display("FAIL ready_rule: ready %b grant %b busy %b", req_ready, grant, tx_busy);
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i] === 1'b1) begin
        void'(pq[i].pop_front());
        hs_cyc = cyc;
      end
  endtask

  task automatic run_until(input int budget);
    int n = 0;
    while ((expq.size() > 0 || pending() > 0 || arb_busy || busy_cnt > 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL drain_budget: %0d bytes still expected after %0d cycles", expq.size(), n);
      expq.delete();
      for (int i = 0; i < N; i++) pq[i].delete();
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      en[i] = 1'b1;
    end
    expq.delete();
    busy_cnt = 0; force_busy = 1'b0; frame_fix = 0;
    repeat (4) cycle();
    rst = 1'b1;
    model_last = N - 1;
    hs_cyc = -10;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b want 0000", grant); end
    checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL rst_tx_wr: got %b want 0", tx_wr); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_arb_busy: got %b want 0", arb_busy); end
    checks++; if (timeout_evt !== 1'b0) begin errors++; $display("FAIL rst_timeout_evt: got %b want 0", timeout_evt); end
  endtask

  task automatic test_single();
    pq[0].push_back({1'b0, 8'h48});
    pq[0].push_back({1'b1, 8'h69});
    model_schedule();
    cycle();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_early: got %b want 0000", grant); end
    cycle();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
    run_until(200);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_end: got %b want 0000", grant); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) pq[i].push_back({1'b1, 8'(8'h10 + i)});
    model_schedule();
    run_until(400);
    pq[2].push_back({1'b1, 8'h22});
    pq[0].push_back({1'b1, 8'h20});
    model_schedule();
    run_until(200);
  endtask

  task automatic test_packet_lock();
    apply_reset();
    pq[0].push_back({1'b1, 8'hA0});
    pq[0].push_back({1'b1, 8'hA1});
    pq[1].push_back({1'b0, 8'hB0});
    pq[1].push_back({1'b0, 8'hB1});
    pq[1].push_back({1'b1, 8'hB2});
    model_schedule();
    run_until(400);
  endtask

  task automatic test_timeout();
    int n = 0;
    n_to = 0; evt_cyc = -1000; frame_fix = 4; en[3] = 1'b0;
    pq[2].push_back({1'b0, 8'hA5});
    pq[2].push_back({1'b1, 8'h5A});
    expq.push_back({2'd2, 8'hA5});
    while (n_to == 0 && n < 300) begin
      cycle();
      n++;
      if (pq[2].size() == 1) en[2] = 1'b0;
    end
    checks++;
    if (evt_cyc - wr_cyc != frame_fix + 1 + TO) begin
      errors++; $display("FAIL timeout_delay: evt %0d cycles after tx_wr, want %0d", evt_cyc - wr_cyc, frame_fix + 1 + TO);
    end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL timeout_grant: got %b want 0000", grant); end
    pq[2].delete();
    en[2] = 1'b1; en[3] = 1'b1;
    pq[3].push_back({1'b1, 8'hC3});
    model_last = 2;
    model_schedule();
    run_until(300);
    checks++; if (n_to != 1) begin errors++; $display("FAIL timeout_count: got %0d pulses want 1", n_to); end
    frame_fix = 0;
  endtask

  task automatic test_busy_hold();
    n_to = 0;
    force_busy = 1'b1;
    pq[0].push_back({1'b1, 8'h77});
    model_schedule();
    for (int k = 0; k < 50; k++) begin
      cycle();
      checks++;
      if (tx_wr !== 1'b0 || req_ready[0] !== 1'b0) begin
        errors++; $display("FAIL busy_hold: cycle %0d tx_wr %b ready0 %b, want 0 0", k, tx_wr, req_ready[0]);
      end
    end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL busy_hold_grant: got %b want 0001", grant); end
    force_busy = 1'b0;
    run_until(200);
    checks++; if (n_to != 0) begin errors++; $display("FAIL busy_hold_timeout: got %0d pulses want 0", n_to); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int w0;
    apply_reset();
    pq[0].push_back({1'b0, 8'h31});
    pq[0].push_back({1'b1, 8'h32});
    model_schedule();
    w0 = n_wr;
    while (n_wr == w0 && n < 200) begin cycle(); n++; end
    rst = 1'b0;
    pq[0].delete(); expq.delete();
    cycle();
    checks++;
    if (grant !== 4'b0000 || tx_wr !== 1'b0 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid: grant %b tx_wr %b arb_busy %b, want 0000 0 0", grant, tx_wr, arb_busy);
    end
    busy_cnt = 0;
    cycle();
    rst = 1'b1;
    model_last = N - 1;
    for (int i = N - 1; i >= 0; i--) pq[i].push_back({1'b1, 8'(8'h40 + i)});
    model_schedule();
    run_until(400);
  endtask

  task automatic test_random();
    int np, len;
    for (int it = 0; it < 15; it++) begin
      n_to = 0;
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) pq[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
        end
      end
      model_schedule();
      run_until(3000);
      checks++; if (n_to != 0) begin errors++; $display("FAIL random_timeout: iteration %0d got %0d pulses want 0", it, n_to); end
    end
  endtask

  initial begin
    cyc = 0; n_wr = 0; n_to = 0; wr_cyc = 0; evt_cyc = -1000;
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_busy_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
